// File: rtl/stable_output_driver_pkg.sv
// stable_output_driver_pkg: shared state encoding for the stable output driver family
package stable_output_driver_pkg;
    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/stable_output_driver_hold_timer.sv
// hold_timer: loadable down-counter that flags when the minimum hold time has elapsed
module hold_timer #(
    parameter int timerWidth = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [timerWidth-1:0] loadValue,
    input  logic                  decrement,
    output logic                  zero
);
    logic [timerWidth-1:0] timer;

    // Load has priority; the decrement is only requested when the count is nonzero.
    always_ff @(posedge clock) begin
        if (reset) timer <= '0;
        else if (load) timer <= loadValue;
        else if (decrement) timer <= timer - 1'b1;
    end

    assign zero = (timer == '0);
endmodule

// File: rtl/stable_output_driver.sv
// stable_output_driver: drives a 1-bit output so each new value holds for holdCycles+1 periods; STABLE_OUTPUT_DRIVER_COALESCE_EN makes the pending slot latest-wins
module stable_output_driver
    import stable_output_driver_pkg::*;
#(
    parameter int                  timerWidth = 4,
    parameter logic [timerWidth-1:0] holdCycles = 4'd15,
    parameter logic                resetValue = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic writeValid,
    input  logic writeData,
    output logic writeReady,
    output logic dataOut,
    output logic busy,
    output logic pending
);
    state_t state;
    logic   pendingValid;
    logic   pendingData;
    logic   accept;
    logic   timerZero;
    logic   expiring;
    logic   candValid;
    logic   candData;
    logic   apply;

`ifdef STABLE_OUTPUT_DRIVER_COALESCE_EN
    assign writeReady = 1'b1;
    assign candData   = (pendingValid && !accept) ? pendingData : writeData;
`else
    assign writeReady = !pendingValid;
    assign candData   = pendingValid ? pendingData : writeData;
`endif

    assign accept    = writeValid && writeReady;
    assign expiring  = (state == STATE_IDLE) || timerZero;
    assign candValid = pendingValid || accept;
    assign apply     = expiring && candValid && (candData != dataOut);
    assign busy      = (state == STATE_HOLD);
    assign pending   = pendingValid;

    hold_timer #(.timerWidth(timerWidth)) holdTimer (
        .clock    (clock),
        .reset    (reset),
        .load     (apply),
        .loadValue(holdCycles),
        .decrement((state == STATE_HOLD) && !timerZero),
        .zero     (timerZero)
    );

    // Output register, FSM and pending slot; a new value is driven only once the previous hold has expired.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataOut      <= resetValue;
            state        <= STATE_IDLE;
            pendingValid <= 1'b0;
            pendingData  <= 1'b0;
        end else begin
            if (apply) begin
                dataOut <= candData;
                state   <= STATE_HOLD;
            end else if (expiring) begin
                state <= STATE_IDLE;
            end
            if (state == STATE_HOLD && timerZero) begin
                pendingValid <= 1'b0;
            end else if (state == STATE_HOLD && accept) begin
                pendingValid <= 1'b1;
                pendingData  <= writeData;
            end
        end
    end
endmodule

// File: tb/tb_stable_output_driver.sv
// tb_stable_output_driver: scoreboard bench comparing two driver configurations against an edge-count reference model
module tb_stable_output_driver;
`ifdef STABLE_OUTPUT_DRIVER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif
    localparam int HA = 3;
    localparam bit RA = 1'b0;
    localparam int HB = 0;
    localparam bit RB = 1'b1;

    typedef struct {
        bit out;
        int last;
        bit hold;
        bit pv;
        bit pd;
    } model_t;

    logic clock = 1'b0;
    logic reset, writeValid, writeData;
    logic readyA, dataA, busyA, pendA;
    logic readyB, dataB, busyB, pendB;
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    model_t ma, mb;
    int edgeN = 0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    stable_output_driver #(.timerWidth(4), .holdCycles(4'(HA)), .resetValue(RA)) dutA (
        .clock(clock), .reset(reset), .writeValid(writeValid), .writeData(writeData),
        .writeReady(readyA), .dataOut(dataA), .busy(busyA), .pending(pendA)
    );

    stable_output_driver #(.timerWidth(4), .holdCycles(4'(HB)), .resetValue(RB)) dutB (
        .clock(clock), .reset(reset), .writeValid(writeValid), .writeData(writeData),
        .writeReady(readyB), .dataOut(dataB), .busy(busyB), .pending(pendB)
    );

    // A value applied at edge `last` must survive edges last..last+h; edge last+h+1 is the first that may change it.
    function automatic model_t step(input model_t m, input int n, input bit r, input bit v,
                                    input bit d, input int h, input bit rv);
        bit acc, has, cand;
        acc = v && (COAL || !m.pv);
        if (r) begin
            m.out = rv;
            m.hold = 0;
            m.pv = 0;
            return m;
        end
        if (m.hold && n <= m.last + h) begin
            if (acc) begin
                m.pv = 1;
                m.pd = d;
            end
            return m;
        end
        has = acc;
        cand = d;
        if (m.hold && m.pv) begin
            has = 1;
            cand = (COAL && acc) ? d : m.pd;
            m.pv = 0;
        end
        if (has && cand != m.out) begin
            m.out = cand;
            m.last = n;
            m.hold = 1;
        end else begin
            m.hold = 0;
        end
        return m;
    endfunction

    function automatic logic [3:0] expect_of(input model_t m);
        return {m.out, m.hold, m.pv, COAL || !m.pv};
    endfunction

    task automatic cycle(input bit r, input bit v, input bit d);
        reset = r;
        writeValid = v;
        writeData = d;
        @(posedge clock);
        edgeN++;
        ma = step(ma, edgeN, r, v, d, HA, RA);
        mb = step(mb, edgeN, r, v, d, HB, RB);
        qa.push_back(expect_of(ma));
        qb.push_back(expect_of(mb));
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0);
    endtask

    // Monitor: the DUTs present a settled output every period; compare against the oldest prediction.
    always @(negedge clock) begin
        logic [3:0] e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            if ({dataA, busyA, pendA, readyA} !== e) begin
                errors++;
                $display("FAIL hold3 edge %0d: {dataOut,busy,pending,writeReady} got %b expected %b",
                         edgeN, {dataA, busyA, pendA, readyA}, e);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            if ({dataB, busyB, pendB, readyB} !== e) begin
                errors++;
                $display("FAIL hold0 edge %0d: {dataOut,busy,pending,writeReady} got %b expected %b",
                         edgeN, {dataB, busyB, pendB, readyB}, e);
            end
        end
    end

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        idle(1);
        cycle(0, 1, 1);
        idle(5);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        idle(6);
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        idle(8);
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        cycle(1, 1, 1);
        cycle(0, 1, 1);
        idle(6);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1);
        idle(2);
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: queue sizes got %0d/%0d expected 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
